motoro3_pwm_capture: RTL

- Measures the PWM stream driven onto one motor phase and returns the results to the step sequencer as feedback.
- Decodes high time, period and accumulated on-time per commutation step.
- Compares the accumulated on-time against the wanted position count for the step and reports the signed loss.
- Flags pulses shorter than the minimum MOSFET on-time (runts) and a stuck output line.

---
 rtl/motoro3_pwm_capture.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/motoro3_pwm_capture.sv
// PWM capture for one motor phase: measures high time and period, accumulates
// on-time per commutation step, and flags runt pulses and a stuck line.
module motoro3_pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PULSE   = 32,
    parameter int unsigned TIMEOUT     = 4095
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        enable,
    input  logic        pwmIn,
    input  logic [3:0]  sgStep,
    input  logic        stepStart,
    input  logic        stepEnd,
    input  logic [15:0] posWant,
    output logic [11:0] highLen,
    output logic [11:0] periodLen,
    output logic        measValid,
    output logic [15:0] stepReal,
    output logic [15:0] stepLost,
    output logic [3:0]  stepIdx,
    output logic        stepValid,
    output logic        runtFlag,
    output logic        stuckFlag,
    output logic [7:0]  errCnt,
    input  logic        clrFlags
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [11:0]   MIN_PULSE_W  = 12'(MIN_PULSE);
    localparam logic [IW-1:0] TIMEOUT_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_prev_q;
    logic                   pwm_s, rise_det, fall_det;

    logic [11:0]   hi_cnt_q, hi_cnt_d;
    logic [11:0]   per_cnt_q, per_cnt_d;
    logic [IW-1:0] edge_idle_q, edge_idle_d;

    logic [11:0] high_len_q, high_len_d;
    logic [11:0] period_len_q, period_len_d;
    logic        meas_valid_q, meas_valid_d;

    logic        runt_flag_q, runt_flag_d;
    logic        stuck_flag_q, stuck_flag_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        runt_set, stuck_set;

    logic [15:0] acc_q, acc_d;
    logic [16:0] acc_sum;
    logic [15:0] acc_sat;
    logic [15:0] step_real_q, step_real_d;
    logic [15:0] step_lost_q, step_lost_d;
    logic [3:0]  step_idx_q, step_idx_d;
    logic        step_valid_q, step_valid_d;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign pwm_s    = sync_q[SYNC_STAGES-1];
    assign rise_det = pwm_s & ~pwm_prev_q;
    assign fall_det = ~pwm_s & pwm_prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwmIn};
    end

    // Period FSM; stuck timeout overrides the per-state action in every active state
    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        per_cnt_d    = per_cnt_q;
        edge_idle_d  = edge_idle_q;
        high_len_d   = high_len_q;
        period_len_d = period_len_q;
        meas_valid_d = 1'b0;
        runt_set     = 1'b0;
        stuck_set    = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            hi_cnt_d    = '0;
            per_cnt_d   = '0;
            edge_idle_d = '0;
        end else if (state_q == IDLE) begin
            state_d     = WAIT_RISE;
            edge_idle_d = '0;
        end else begin
            if (rise_det || fall_det) begin
                edge_idle_d = '0;
            end else begin
                edge_idle_d = edge_idle_q + IW'(1);
            end

            if (!rise_det && !fall_det && (edge_idle_q == TIMEOUT_LAST)) begin
                stuck_set   = 1'b1;
                edge_idle_d = '0;
                hi_cnt_d    = '0;
                per_cnt_d   = '0;
                state_d     = WAIT_RISE;
            end else begin
                case (state_q)
                    WAIT_RISE: begin
                        if (rise_det) begin
                            hi_cnt_d  = 12'd1;
                            per_cnt_d = 12'd1;
                            state_d   = HIGH;
                        end
                    end
                    HIGH: begin
                        per_cnt_d = sat_inc12(per_cnt_q);
                        if (fall_det) begin
                            runt_set = (hi_cnt_q < MIN_PULSE_W);
                            state_d  = LOW;
                        end else begin
                            hi_cnt_d = sat_inc12(hi_cnt_q);
                        end
                    end
                    LOW: begin
                        if (rise_det) begin
                            high_len_d   = hi_cnt_q;
                            period_len_d = per_cnt_q;
                            meas_valid_d = 1'b1;
                            hi_cnt_d     = 12'd1;
                            per_cnt_d    = 12'd1;
                            state_d      = HIGH;
                        end else begin
                            per_cnt_d = sat_inc12(per_cnt_q);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Clear is applied first so that a simultaneous set survives it
    always_comb begin
        runt_flag_d  = clrFlags ? 1'b0 : runt_flag_q;
        stuck_flag_d = clrFlags ? 1'b0 : stuck_flag_q;
        err_cnt_d    = clrFlags ? 8'd0 : err_cnt_q;
        if (runt_set) begin
            runt_flag_d = 1'b1;
            if (err_cnt_d != 8'hFF) begin
                err_cnt_d = err_cnt_d + 8'd1;
            end
        end
        if (stuck_set) begin
            stuck_flag_d = 1'b1;
        end
    end

    always_comb begin
        acc_sum      = {1'b0, acc_q} + {16'd0, pwm_s};
        acc_sat      = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        acc_d        = acc_q;
        step_real_d  = step_real_q;
        step_lost_d  = step_lost_q;
        step_idx_d   = step_idx_q;
        step_valid_d = 1'b0;

        if (!enable) begin
            acc_d = '0;
        end else begin
            acc_d = acc_sat;
            if (stepEnd) begin
                step_real_d  = acc_sat;
                step_lost_d  = posWant - acc_sat;
                step_idx_d   = sgStep;
                step_valid_d = 1'b1;
                acc_d        = '0;
            end
            if (stepStart) begin
                acc_d = {15'd0, pwm_s};
            end
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            pwm_prev_q   <= 1'b0;
            hi_cnt_q     <= '0;
            per_cnt_q    <= '0;
            edge_idle_q  <= '0;
            high_len_q   <= '0;
            period_len_q <= '0;
            meas_valid_q <= 1'b0;
            runt_flag_q  <= 1'b0;
            stuck_flag_q <= 1'b0;
            err_cnt_q    <= '0;
            acc_q        <= '0;
            step_real_q  <= '0;
            step_lost_q  <= '0;
            step_idx_q   <= '0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            pwm_prev_q   <= pwm_s;
            hi_cnt_q     <= hi_cnt_d;
            per_cnt_q    <= per_cnt_d;
            edge_idle_q  <= edge_idle_d;
            high_len_q   <= high_len_d;
            period_len_q <= period_len_d;
            meas_valid_q <= meas_valid_d;
            runt_flag_q  <= runt_flag_d;
            stuck_flag_q <= stuck_flag_d;
            err_cnt_q    <= err_cnt_d;
            acc_q        <= acc_d;
            step_real_q  <= step_real_d;
            step_lost_q  <= step_lost_d;
            step_idx_q   <= step_idx_d;
            step_valid_q <= step_valid_d;
        end
    end

    assign highLen   = high_len_q;
    assign periodLen = period_len_q;
    assign measValid = meas_valid_q;
    assign stepReal  = step_real_q;
    assign stepLost  = step_lost_q;
    assign stepIdx   = step_idx_q;
    assign stepValid = step_valid_q;
    assign runtFlag  = runt_flag_q;
    assign stuckFlag = stuck_flag_q;
    assign errCnt    = err_cnt_q;

endmodule
